// File: rtl/playback_feeder_pkg.sv
// Shared constants, FSM state encoding and the latched playback-mode payload
// for the playback feeder and its divider.
package playback_feeder_pkg;

    localparam int unsigned DEF_ADDR_W = 20;
    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned SPEED_W    = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_DATA,
        S_CALC,
        S_READY,
        S_ADVANCE
    } state_t;

    // Mode captured at start; linear is pre-qualified so N=1 behaves as repeat.
    typedef struct packed {
        logic               slow;
        logic               linear;
        logic [SPEED_W-1:0] speed;
    } mode_t;

endpackage

// File: rtl/playback_feeder_if.sv
// Sample SRAM read handshake: address/request out, one-cycle valid with data back.
interface playback_feeder_if #(
    parameter int unsigned ADDR_W = playback_feeder_pkg::DEF_ADDR_W,
    parameter int unsigned DATA_W = playback_feeder_pkg::DEF_DATA_W
);
    logic [ADDR_W-1:0] sram_addr;
    logic              sram_rd_req;
    logic              sram_rd_valid;
    logic [DATA_W-1:0] sram_rdata;

    modport master (output sram_addr, sram_rd_req, input sram_rd_valid, sram_rdata);
    modport slave  (input sram_addr, sram_rd_req, output sram_rd_valid, sram_rdata);
endinterface

// File: rtl/playback_feeder_seq_sdiv.sv
// Sequential signed divider: restoring division on magnitudes, sign applied at
// the end so the quotient truncates toward zero. done follows start by DVD_W+1 cycles.
module playback_feeder_seq_sdiv #(
    parameter int unsigned DVD_W = 20,
    parameter int unsigned DVR_W = 4,
    parameter int unsigned QUO_W = 16
) (
    input  logic                    clk_n,
    input  logic                    rst,
    input  logic                    start,
    input  logic signed [DVD_W-1:0] dividend,
    input  logic [DVR_W-1:0]        divisor,
    output logic                    done,
    output logic [QUO_W-1:0]        quotient
);
    localparam int unsigned CNT_W = $clog2(DVD_W + 1);

    logic [DVD_W-1:0] mag;
    logic [DVR_W-1:0] rem;
    logic [CNT_W-1:0] cnt;
    logic             neg;
    logic             run;
    logic [DVR_W:0]   trial;

    always_comb trial = {rem, mag[DVD_W-1]};

    always_ff @(negedge clk_n) begin
        if (rst) begin
            mag      <= '0;
            rem      <= '0;
            cnt      <= '0;
            neg      <= 1'b0;
            run      <= 1'b0;
            done     <= 1'b0;
            quotient <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                run <= 1'b1;
                cnt <= CNT_W'(DVD_W);
                rem <= '0;
                neg <= dividend[DVD_W-1];
                mag <= dividend[DVD_W-1] ? DVD_W'(-dividend) : DVD_W'(dividend);
            end else if (run) begin
                if (cnt != '0) begin
                    if (trial >= {1'b0, divisor}) begin
                        rem <= DVR_W'(trial - {1'b0, divisor});
                        mag <= {mag[DVD_W-2:0], 1'b1};
                    end else begin
                        rem <= DVR_W'(trial);
                        mag <= {mag[DVD_W-2:0], 1'b0};
                    end
                    cnt <= cnt - CNT_W'(1);
                end else begin
                    run      <= 1'b0;
                    done     <= 1'b1;
                    quotient <= neg ? QUO_W'(-$signed(mag)) : QUO_W'($signed(mag));
                end
            end
        end
    end

endmodule

// File: rtl/playback_feeder.sv
// Fetches PCM samples from SRAM, applies skip/repeat/interpolate speed control
// and hands exactly one sample per daclrc frame to the I2S serializer.
module playback_feeder
    import playback_feeder_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic                clk_n,
    input  logic                rst,
    input  logic                daclrc,
    input  logic                start,
    input  logic                stop,
    input  logic                pause,
    input  logic [ADDR_W-1:0]   start_addr,
    input  logic [ADDR_W-1:0]   end_addr,
    input  logic                slow,
    input  logic                interp,
    input  logic [SPEED_W-1:0]  speed,
    playback_feeder_if.master   sram,
    output logic [DATA_W-1:0]   data,
    output logic                data_en,
    output logic                busy,
    output logic                done,
    output logic                underrun
);
    localparam int unsigned AP1_W  = ADDR_W + 1;
    localparam int unsigned DIFF_W = DATA_W + 1;
    localparam int unsigned PROD_W = DATA_W + 1 + SPEED_W;
    localparam int unsigned DIVR_W = SPEED_W + 1;

    state_t              state;
    mode_t               mode;
    logic [ADDR_W-1:0]   addr;
    logic [ADDR_W-1:0]   end_q;
    logic [DATA_W-1:0]   prev;
    logic [DATA_W-1:0]   cur;
    logic [DATA_W-1:0]   sample;
    logic [SPEED_W-1:0]  k;
    logic                daclrc_q;
    logic                tail;
    logic                div_go;
    logic                div_wait;
    logic                div_done;
    logic [DATA_W-1:0]   quot;

    logic                     tick;
    logic [AP1_W-1:0]         step;
    logic [AP1_W-1:0]         next_addr;
    logic                     past_end;
    logic                     wrap;
    logic signed [DIFF_W-1:0] diff;
    logic signed [PROD_W-1:0] prod;
    logic [DIVR_W-1:0]        divisor;
    logic [DATA_W-1:0]        interp_val;

    // Address step and end test are one bit wider so a wrapping address still reads as past the end.
    always_comb begin
        tick       = daclrc & ~daclrc_q;
        step       = mode.slow ? AP1_W'(1) : AP1_W'(mode.speed) + AP1_W'(1);
        next_addr  = {1'b0, addr} + step;
        past_end   = next_addr > {1'b0, end_q};
        wrap       = (k == mode.speed);
        diff       = $signed({cur[DATA_W-1], cur}) - $signed({prev[DATA_W-1], prev});
        prod       = PROD_W'(diff) * $signed(PROD_W'({1'b0, k}));
        divisor    = DIVR_W'(mode.speed) + DIVR_W'(1);
        interp_val = prev + quot;
    end

    playback_feeder_seq_sdiv #(
        .DVD_W (PROD_W),
        .DVR_W (DIVR_W),
        .QUO_W (DATA_W)
    ) u_div (
        .clk_n    (clk_n),
        .rst      (rst),
        .start    (div_go),
        .dividend (prod),
        .divisor  (divisor),
        .done     (div_done),
        .quotient (quot)
    );

    always_ff @(negedge clk_n) begin
        if (rst) begin
            state            <= S_IDLE;
            mode             <= '0;
            addr             <= '0;
            end_q            <= '0;
            prev             <= '0;
            cur              <= '0;
            sample           <= '0;
            k                <= '0;
            daclrc_q         <= 1'b0;
            tail             <= 1'b0;
            div_go           <= 1'b0;
            div_wait         <= 1'b0;
            sram.sram_addr   <= '0;
            sram.sram_rd_req <= 1'b0;
            data             <= '0;
            data_en          <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            underrun         <= 1'b0;
        end else begin
            daclrc_q <= daclrc;
            data_en  <= 1'b0;
            done     <= 1'b0;
            underrun <= 1'b0;
            div_go   <= 1'b0;

            // Frame output: silence unless a sample is ready and playback is not paused.
            if (tick) begin
                data_en <= 1'b1;
                data    <= '0;
                if (state == S_READY && !pause) begin
                    data <= sample;
                end else if (state != S_IDLE && !pause) begin
                    underrun <= 1'b1;
                end
            end

            if (stop) begin
                state            <= S_IDLE;
                busy             <= 1'b0;
                sram.sram_rd_req <= 1'b0;
                div_wait         <= 1'b0;
            end else if (start) begin
                mode             <= '{slow: slow, linear: slow & interp & (speed != '0), speed: speed};
                end_q            <= end_addr;
                addr             <= start_addr;
                prev             <= '0;
                k                <= '0;
                tail             <= 1'b0;
                busy             <= 1'b1;
                sram.sram_rd_req <= 1'b0;
                div_wait         <= 1'b0;
                state            <= S_FETCH;
            end else begin
                case (state)
                    S_FETCH: begin
                        sram.sram_addr   <= addr;
                        sram.sram_rd_req <= 1'b1;
                        state            <= S_WAIT_DATA;
                    end
                    S_WAIT_DATA: begin
                        if (sram.sram_rd_valid) begin
                            cur              <= sram.sram_rdata;
                            sram.sram_rd_req <= 1'b0;
                            state            <= S_CALC;
                        end
                    end
                    // A done seen while div_go is still pending belongs to an abandoned division.
                    S_CALC: begin
                        if (!mode.linear) begin
                            sample <= cur;
                            state  <= S_READY;
                        end else if (!div_wait) begin
                            div_go   <= 1'b1;
                            div_wait <= 1'b1;
                        end else if (div_done && !div_go) begin
                            sample   <= interp_val;
                            div_wait <= 1'b0;
                            state    <= S_READY;
                        end
                    end
                    S_READY: begin
                        if (tick && !pause) state <= S_ADVANCE;
                    end
                    S_ADVANCE: begin
                        if (!mode.slow) begin
                            if (past_end) begin
                                state <= S_IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                addr  <= ADDR_W'(next_addr);
                                state <= S_FETCH;
                            end
                        end else if (tail) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else if (!wrap) begin
                            k     <= k + SPEED_W'(1);
                            state <= S_CALC;
                        end else begin
                            k <= '0;
                            if (mode.linear) prev <= cur;
                            if (!past_end) begin
                                addr  <= ADDR_W'(next_addr);
                                state <= S_FETCH;
                            end else if (mode.linear) begin
                                // Linear mode still owes the final endpoint sample.
                                tail  <= 1'b1;
                                state <= S_CALC;
                            end else begin
                                state <= S_IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_playback_feeder.sv
// Bench for playback_feeder: directed speed/pause/underrun/stop scenarios plus
// randomized playbacks checked against a frame-level reference model.
module tb_playback_feeder;

    localparam int unsigned AW   = 20;
    localparam int unsigned DW   = 16;
    localparam int unsigned HALF = 40;

    logic          clk_n = 1'b0;
    logic          rst = 1'b1;
    logic          daclrc = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          pause = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [AW-1:0] end_addr = '0;
    logic          slow = 1'b0;
    logic          interp = 1'b0;
    logic [2:0]    speed = '0;
    logic [DW-1:0] data;
    logic          data_en, busy, done, underrun;

    playback_feeder_if #(.ADDR_W(AW), .DATA_W(DW)) sram ();

    playback_feeder #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_n      (clk_n),
        .rst        (rst),
        .daclrc     (daclrc),
        .start      (start),
        .stop       (stop),
        .pause      (pause),
        .start_addr (start_addr),
        .end_addr   (end_addr),
        .slow       (slow),
        .interp     (interp),
        .speed      (speed),
        .sram       (sram),
        .data       (data),
        .data_en    (data_en),
        .busy       (busy),
        .done       (done),
        .underrun   (underrun)
    );

    int n_vec = 0;
    int n_err = 0;
    int lat = 2;
    logic [DW-1:0] mem [0:255];
    int exp_q[$];

    always #5 clk_n = ~clk_n;

    initial forever begin
        repeat (HALF) @(posedge clk_n);
        daclrc = ~daclrc;
    end

    // SRAM: latency counted from the first cycle a request is seen; a fetch abandoned
    // by the DUT still answers later.
    initial begin
        bit            pend;
        int            cnt;
        logic [AW-1:0] raddr;
        pend = 1'b0;
        cnt = 0;
        raddr = '0;
        sram.sram_rd_valid = 1'b0;
        sram.sram_rdata = '0;
        forever begin
            @(posedge clk_n);
            sram.sram_rd_valid = 1'b0;
            if (!pend && sram.sram_rd_req) begin
                pend = 1'b1;
                cnt = lat;
                raddr = sram.sram_addr;
            end else if (pend) begin
                if (cnt <= 1) begin
                    sram.sram_rd_valid = 1'b1;
                    sram.sram_rdata = mem[raddr[7:0]];
                    pend = 1'b0;
                end else begin
                    cnt--;
                end
            end
        end
    end

    initial begin
        #700000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(expv));
        end
    endtask

    // Waits for the next data strobe; also reports underrun/done seen since the previous one.
    task automatic wait_strobe(output logic [DW-1:0] d, output bit u, output bit dn);
        u = 1'b0;
        dn = 1'b0;
        d = 'x;
        for (int i = 0; i < int'(6 * HALF); i++) begin
            @(posedge clk_n);
            if (underrun) u = 1'b1;
            if (done) dn = 1'b1;
            if (data_en) begin
                d = data;
                return;
            end
        end
        chk("strobe_timeout", 32'(data_en), 1);
    endtask

    task automatic play(input logic [AW-1:0] sa, input logic [AW-1:0] ea,
                        input bit sl, input bit it, input logic [2:0] sp);
        logic [DW-1:0] d;
        bit u, dn;
        wait_strobe(d, u, dn);
        start_addr = sa;
        end_addr = ea;
        slow = sl;
        interp = it;
        speed = sp;
        start = 1'b1;
        @(posedge clk_n);
        start = 1'b0;
        slow = 1'($urandom);
        interp = 1'($urandom);
        speed = 3'($urandom);
        end_addr = AW'($urandom);
    endtask

    task automatic expect_frames(input string tag, input int q[$]);
        logic [DW-1:0] d;
        bit u, dn;
        foreach (q[i]) begin
            wait_strobe(d, u, dn);
            chk({tag, "_data"}, 32'($signed(d)), 32'(q[i]));
            chk({tag, "_underrun"}, 32'(u), 0);
            chk({tag, "_early_done"}, 32'(dn), 0);
            chk({tag, "_busy"}, 32'(busy), 1);
        end
        wait_strobe(d, u, dn);
        chk({tag, "_end_data"}, 32'($signed(d)), 0);
        chk({tag, "_done"}, 32'(dn), 1);
        chk({tag, "_end_busy"}, 32'(busy), 0);
        wait_strobe(d, u, dn);
        chk({tag, "_idle_data"}, 32'($signed(d)), 0);
        chk({tag, "_idle_done"}, 32'(dn), 0);
    endtask

    function automatic int s16(input int a);
        return int'($signed(mem[8'(a)]));
    endfunction

    // Frame-level model: list of samples the serializer should receive.
    function automatic void build_model(input int sa, input int ea, input bit sl,
                                        input bit it, input int n);
        int a, p, c;
        exp_q = {};
        a = sa;
        if (!sl) begin
            do begin
                exp_q.push_back(s16(a));
                a += n;
            end while (a <= ea);
        end else if (!it || n == 1) begin
            do begin
                for (int r = 0; r < n; r++) exp_q.push_back(s16(a));
                a++;
            end while (a <= ea);
        end else begin
            p = 0;
            do begin
                c = s16(a);
                for (int kk = 0; kk < n; kk++) exp_q.push_back(p + ((c - p) * kk) / n);
                p = c;
                a++;
            end while (a <= ea);
            exp_q.push_back(p);
        end
    endfunction

    initial begin
        logic [DW-1:0] d;
        bit u, dn;
        int q[$];

        for (int i = 0; i < 256; i++) mem[i] = '0;

        // Reset state
        rst = 1'b1;
        repeat (4) @(posedge clk_n);
        chk("rst_data", 32'(data), 0);
        chk("rst_data_en", 32'(data_en), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_underrun", 32'(underrun), 0);
        chk("rst_rd_req", 32'(sram.sram_rd_req), 0);
        chk("rst_sram_addr", 32'(sram.sram_addr), 0);
        rst = 1'b0;

        // Idle frames are silent
        wait_strobe(d, u, dn);
        chk("idle_data", 32'($signed(d)), 0);
        chk("idle_underrun", 32'(u), 0);

        // Fast, N=1
        mem[0] = 16'd100; mem[1] = 16'd200; mem[2] = 16'd300;
        play(0, 2, 1'b0, 1'b0, 3'd0);
        q = {100, 200, 300};
        expect_frames("fast_n1", q);

        // Fast, N=3 skipping
        for (int i = 0; i < 10; i++) mem[i] = DW'(i);
        play(0, 9, 1'b0, 1'b0, 3'd2);
        q = {0, 3, 6, 9};
        expect_frames("fast_n3", q);

        // Slow repeat, N=2
        mem[0] = 16'd10; mem[1] = 16'hFFEC;
        play(0, 1, 1'b1, 1'b0, 3'd1);
        q = {10, 10, -20, -20};
        expect_frames("repeat_n2", q);

        // Slow linear, N=4
        mem[0] = 16'd0; mem[1] = 16'd100; mem[2] = 16'hFF9C;
        play(0, 2, 1'b1, 1'b1, 3'd3);
        q = {0, 0, 0, 0, 0, 25, 50, 75, 100, 50, 0, -50, -100};
        expect_frames("linear_n4", q);

        // start_addr beyond end_addr: one sample then done
        mem[5] = 16'd555;
        play(5, 3, 1'b0, 1'b0, 3'd0);
        q = {555};
        expect_frames("start_gt_end", q);

        // Late SRAM data: one silent underrun frame, then the late sample
        mem[0] = 16'd100; mem[1] = 16'd200; mem[2] = 16'd300;
        lat = 100;
        play(0, 2, 1'b0, 1'b0, 3'd0);
        wait_strobe(d, u, dn);
        chk("underrun_data", 32'($signed(d)), 0);
        chk("underrun_pulse", 32'(u), 1);
        lat = 2;
        q = {100, 200, 300};
        expect_frames("after_underrun", q);

        // Pause for three frames, resume, then stop while waiting on SRAM
        for (int i = 0; i < 6; i++) mem[i] = DW'(1000 + i);
        play(0, 5, 1'b0, 1'b0, 3'd0);
        wait_strobe(d, u, dn);
        chk("pause_pre0", 32'($signed(d)), 1000);
        wait_strobe(d, u, dn);
        chk("pause_pre1", 32'($signed(d)), 1001);
        pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_strobe(d, u, dn);
            chk("pause_data", 32'($signed(d)), 0);
            chk("pause_underrun", 32'(u), 0);
        end
        pause = 1'b0;
        wait_strobe(d, u, dn);
        chk("resume_data", 32'($signed(d)), 1002);
        lat = 60;
        repeat (10) @(posedge clk_n);
        chk("wait_rd_req", 32'(sram.sram_rd_req), 1);
        stop = 1'b1;
        @(posedge clk_n);
        stop = 1'b0;
        chk("stop_rd_req", 32'(sram.sram_rd_req), 0);
        chk("stop_busy", 32'(busy), 0);
        for (int i = 0; i < 2; i++) begin
            wait_strobe(d, u, dn);
            chk("stop_data", 32'($signed(d)), 0);
            chk("stop_no_done", 32'(dn), 0);
            chk("stop_underrun", 32'(u), 0);
        end
        chk("stop_late_valid_ignored", 32'(sram.sram_rd_req), 0);
        lat = 2;

        // start and stop together: stop wins
        @(posedge clk_n);
        start = 1'b1;
        stop = 1'b1;
        @(posedge clk_n);
        start = 1'b0;
        stop = 1'b0;
        @(posedge clk_n);
        chk("start_stop_busy", 32'(busy), 0);
        chk("start_stop_rd_req", 32'(sram.sram_rd_req), 0);

        // Randomized playbacks against the reference model
        for (int r = 0; r < 6; r++) begin
            int sa, len, n;
            bit sl, it;
            sl = 1'($urandom);
            it = 1'($urandom);
            n = int'($urandom_range(1, 8));
            len = sl ? int'($urandom_range(1, 3)) : int'($urandom_range(1, 12));
            sa = int'($urandom_range(16, 200));
            for (int i = 0; i < len; i++) mem[8'(sa + i)] = DW'($urandom);
            lat = int'($urandom_range(1, 4));
            build_model(sa, sa + len - 1, sl, it, n);
            play(AW'(sa), AW'(sa + len - 1), sl, it, 3'(n - 1));
            expect_frames($sformatf("rand%0d", r), exp_q);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
